gray_counter_param: RTL and testbench

- Parametrised successor to the 3-bit Gray sequence counter used in the P1 exercises.
- Counts in reflected binary Gray code over WIDTH bits.
- Adds up/down direction, synchronous load, an optional saturate mode, sticky overflow/underflow flags with explicit clear, a one-cycle wrap pulse and a binary shadow output.
- Standalone leaf block; drives displays, pointer logic or testbench sequencing.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray2bin_conv.sv | 15 +
 rtl/gray_counter_param.sv | 90 +++++++++
 tb/tb_gray_counter_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers, written at the widest supported width
// so callers zero-extend their operand and truncate the result back to WIDTH.
package gray_pkg;

    localparam int unsigned MAX_W = 16;
    localparam logic [MAX_W-1:0] MAX_BIN = '1;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = int'(MAX_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter for the load path.
module gray2bin_conv
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin_c
);

    always_comb begin
        bin_c = WIDTH'(gray2bin(MAX_W'(gray)));
    end

endmodule

// File: rtl/gray_counter_param.sv
// Up/down Gray-code counter with load, optional saturation, sticky
// overflow/underflow flags, a boundary pulse and a binary shadow output.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_val,
    input  logic             Clr_flags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Bin,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX = MAX_BIN[WIDTH-1:0];

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic [WIDTH-1:0] load_bin;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             wrap_nxt;

    gray2bin_conv #(
        .WIDTH (WIDTH)
    ) u_load_conv (
        .gray  (Load_val),
        .bin_c (load_bin)
    );

    // Next count and flags; a boundary event overrides a same-edge flag clear.
    always_comb begin
        cnt_nxt  = cnt;
        ovf_nxt  = Clr_flags ? 1'b0 : Overflow;
        unf_nxt  = Clr_flags ? 1'b0 : Underflow;
        wrap_nxt = 1'b0;
        if (Load) begin
            cnt_nxt = load_bin;
        end else if (En && Up) begin
            if (cnt == MAX) begin
                ovf_nxt  = 1'b1;
                wrap_nxt = 1'b1;
                if (!SATURATE) begin
                    cnt_nxt = '0;
                end
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
            end
        end else if (En) begin
            if (cnt == '0) begin
                unf_nxt  = 1'b1;
                wrap_nxt = 1'b1;
                if (!SATURATE) begin
                    cnt_nxt = MAX;
                end
            end else begin
                cnt_nxt = cnt - WIDTH'(1);
            end
        end
        gray_nxt = WIDTH'(bin2gray(MAX_W'(cnt_nxt)));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt       <= '0;
            Output    <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            Wrap      <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            Output    <= gray_nxt;
            Overflow  <= ovf_nxt;
            Underflow <= unf_nxt;
            Wrap      <= wrap_nxt;
        end
    end

    assign Bin = cnt;

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench: three counter configurations driven by shared stimulus.
module tb_gray_counter_param;

    logic       Clk;
    logic       Reset;
    logic       En;
    logic       Up;
    logic       Load;
    logic       Clr_flags;
    logic [2:0] lv3;
    logic [3:0] lv4;

    logic [2:0] o3, b3, o3s, b3s;
    logic [3:0] o4, b4;
    logic       ov3, un3, w3, ov3s, un3s, w3s, ov4, un4, w4;

    int checks = 0;
    int errors = 0;

    gray_counter_param #(.WIDTH(3), .SATURATE(1'b0)) dut3 (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .Load_val(lv3),
        .Clr_flags(Clr_flags), .Output(o3), .Bin(b3), .Overflow(ov3),
        .Underflow(un3), .Wrap(w3)
    );

    gray_counter_param #(.WIDTH(3), .SATURATE(1'b1)) dut3s (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .Load_val(lv3),
        .Clr_flags(Clr_flags), .Output(o3s), .Bin(b3s), .Overflow(ov3s),
        .Underflow(un3s), .Wrap(w3s)
    );

    gray_counter_param #(.WIDTH(4), .SATURATE(1'b0)) dut4 (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .Load_val(lv4),
        .Clr_flags(Clr_flags), .Output(o4), .Bin(b4), .Overflow(ov4),
        .Underflow(un4), .Wrap(w4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [2:0] up_seq [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

    initial begin
        Reset = 1'b0; En = 1'b0; Up = 1'b0; Load = 1'b0; Clr_flags = 1'b0;
        lv3 = '0; lv4 = '0;
        #2;
        chk("rst_out", 16'(o3), 16'h0);
        chk("rst_bin", 16'(b3), 16'h0);
        chk("rst_ovf", 16'(ov3), 16'h0);
        chk("rst_unf", 16'(un3), 16'h0);
        chk("rst_wrap", 16'(w3), 16'h0);

        // Edges are ignored while reset is held.
        En = 1'b1; Up = 1'b1;
        step();
        chk("rst_hold_out", 16'(o3), 16'h0);
        @(negedge Clk);
        Reset = 1'b1;

        // Full up sweep with wrap on the eighth edge.
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("up_out_%0d", i), 16'(o3), 16'(up_seq[i]));
            chk($sformatf("up_wrap_%0d", i), 16'(w3), (i == 7) ? 16'h1 : 16'h0);
        end
        chk("up_ovf", 16'(ov3), 16'h1);
        chk("up_unf", 16'(un3), 16'h0);
        chk("up_bin", 16'(b3), 16'h0);
        En = 1'b0;
        step();
        chk("idle_wrap", 16'(w3), 16'h0);
        chk("idle_ovf_sticky", 16'(ov3), 16'h1);
        chk("idle_out", 16'(o3), 16'h0);

        // Down-wrap from zero after a fresh reset.
        Reset = 1'b0;
        #1;
        chk("rst2_ovf", 16'(ov3), 16'h0);
        @(negedge Clk);
        Reset = 1'b1;
        En = 1'b1; Up = 1'b0;
        step();
        chk("dn_out", 16'(o3), 16'b100);
        chk("dn_bin", 16'(b3), 16'd7);
        chk("dn_unf", 16'(un3), 16'h1);
        chk("dn_wrap", 16'(w3), 16'h1);
        chk("dn_sat_out", 16'(o3s), 16'h0);
        chk("dn4_out", 16'(o4), 16'b1000);
        chk("dn4_bin", 16'(b4), 16'd15);
        step();
        chk("dn2_out", 16'(o3), 16'b101);
        chk("dn2_bin", 16'(b3), 16'd6);
        chk("dn2_wrap", 16'(w3), 16'h0);
        chk("dn2_unf", 16'(un3), 16'h1);

        // Load has priority over counting.
        Load = 1'b1; lv3 = 3'b110; Up = 1'b1;
        step();
        chk("ld_out", 16'(o3), 16'b110);
        chk("ld_bin", 16'(b3), 16'd4);
        chk("ld_wrap", 16'(w3), 16'h0);
        chk("ld_unf_kept", 16'(un3), 16'h1);
        chk("ld_sat_out", 16'(o3s), 16'b110);
        Load = 1'b0;
        step();
        chk("ld_next_out", 16'(o3), 16'b111);

        // Position both 3-bit counters at MAX.
        Load = 1'b1; lv3 = 3'b100; En = 1'b0;
        step();
        chk("ldmax_sat_out", 16'(o3s), 16'b100);
        chk("ldmax_sat_bin", 16'(b3s), 16'd7);
        Load = 1'b0;

        // Overflow set on the same edge as a clear: set wins, the other flag clears.
        En = 1'b1; Up = 1'b1; Clr_flags = 1'b1;
        step();
        chk("clr_out", 16'(o3), 16'b000);
        chk("clr_ovf", 16'(ov3), 16'h1);
        chk("clr_unf", 16'(un3), 16'h0);
        chk("sat1_out", 16'(o3s), 16'b100);
        chk("sat1_ovf", 16'(ov3s), 16'h1);
        chk("sat1_wrap", 16'(w3s), 16'h1);
        Clr_flags = 1'b0;
        step();
        chk("sat2_out", 16'(o3s), 16'b100);
        chk("sat2_ovf", 16'(ov3s), 16'h1);
        chk("sat2_wrap", 16'(w3s), 16'h1);
        chk("wrap_after_out", 16'(o3), 16'b001);
        En = 1'b0; Clr_flags = 1'b1;
        step();
        chk("clr2_ovf", 16'(ov3), 16'h0);
        chk("clr2_sat_ovf", 16'(ov3s), 16'h0);
        chk("clr2_sat_wrap", 16'(w3s), 16'h0);
        Clr_flags = 1'b0;

        // Asynchronous reset mid-count on the 4-bit counter.
        Load = 1'b1; lv4 = 4'b1101;
        step();
        chk("w4_ld_out", 16'(o4), 16'b1101);
        chk("w4_ld_bin", 16'(b4), 16'd9);
        Load = 1'b0; En = 1'b1; Up = 1'b0;
        step();
        chk("w4_dn_out", 16'(o4), 16'b1100);
        En = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        chk("w4_rst_out", 16'(o4), 16'h0);
        chk("w4_rst_bin", 16'(b4), 16'h0);
        chk("w4_rst_flags", 16'({ov4, un4, w4}), 16'h0);
        @(negedge Clk);
        Reset = 1'b1;
        En = 1'b1; Up = 1'b1;
        step();
        chk("w4_first_out", 16'(o4), 16'b0001);
        chk("w4_first_bin", 16'(b4), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
